// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants, state encodings and grid cell helpers
package game_pkg;

   localparam logic [1:0] INIT   = 2'b00;
   localparam logic [1:0] PLAY   = 2'b01;
   localparam logic [1:0] FINISH = 2'b10;

   localparam logic [1:0] LIFE_MAX  = 2'd3;
   localparam logic [3:0] SCORE_MAX = 4'd5;
   localparam int         NUM_BOXES = 9;

   typedef enum logic [1:0] {
      G_INIT   = INIT,
      G_PLAY   = PLAY,
      G_FINISH = FINISH
   } game_fsm_e;

   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_WARN = 2'd1,
      H_FIRE = 2'd2
   } haz_phase_e;

   // Folds a random nibble onto the 3x3 grid; 9..15 wrap to 0..6.
   function automatic logic [3:0] nib_to_cell(input logic [3:0] n);
      return (n < 4'd9) ? n : n - 4'd9;
   endfunction

   function automatic logic [NUM_BOXES-1:0] cell_onehot(input logic [3:0] c);
      logic [NUM_BOXES-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_BOXES; i++) begin
         if (c == 4'(i)) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   function automatic logic [3:0] cell_next(input logic [3:0] c);
      return (c == 4'(NUM_BOXES - 1)) ? 4'd0 : c + 4'd1;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   logic [15:0] r_q;
   logic        w_fb;

   assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= SEED;
      end else begin
         r_q <= {r_q[14:0], w_fb};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - game FSM, tick divider, hazard/gold scheduling and life/score keeping
module hazard_scheduler
   import game_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 25_000_000,
   parameter int unsigned WARN_TICKS = 2,
   parameter int unsigned FIRE_TICKS = 2,
   parameter int unsigned GOLD_TICKS = 3,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [8:0] box,
   output logic [1:0] game_state,
   output logic [8:0] warning_state,
   output logic [8:0] fire_state,
   output logic [8:0] gold_state,
   output logic [1:0] life,
   output logic [3:0] score
);

   localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned HC_MAX = (WARN_TICKS > FIRE_TICKS) ? WARN_TICKS : FIRE_TICKS;
   localparam int unsigned HC_W   = $clog2(HC_MAX + 1);
   localparam int unsigned GC_W   = $clog2(GOLD_TICKS + 1);

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [HC_W-1:0]  WARN_LAST = HC_W'(WARN_TICKS - 1);
   localparam logic [HC_W-1:0]  FIRE_LAST = HC_W'(FIRE_TICKS - 1);
   localparam logic [GC_W-1:0]  GOLD_LAST = GC_W'(GOLD_TICKS - 1);

   game_fsm_e        r_state;
   logic [1:0]       r_life;
   logic [3:0]       r_score;
   logic [CNT_W-1:0] r_tick_cnt;

   haz_phase_e       r_hphase;
   logic [HC_W-1:0]  r_hcnt;
   logic [3:0]       r_hcell;
   logic [8:0]       r_warn;
   logic [8:0]       r_fire;
   logic             r_hit_done;

   logic [8:0]       r_gold;
   logic [GC_W-1:0]  r_gcnt;

   logic [15:0]      w_lfsr;
   logic [7:0]       w_unused_lfsr;
   logic             w_play;
   logic             w_tick;
   logic [3:0]       w_new_hcell;
   logic [3:0]       w_haz_cell;
   logic [3:0]       w_gold_raw;
   logic [3:0]       w_gold_cell;
   logic             w_hit;
   logic             w_collect;
   logic [1:0]       w_life_nxt;
   logic [3:0]       w_score_nxt;
   logic             w_end;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (w_lfsr)
   );

   assign w_unused_lfsr = w_lfsr[15:8];

   assign w_play = (r_state == G_PLAY);
   assign w_tick = w_play && (r_tick_cnt == TICK_LAST);

   // In H_IDLE the cell about to be latched on this tick is the one gold must avoid.
   assign w_new_hcell = nib_to_cell(w_lfsr[3:0]);
   assign w_haz_cell  = (r_hphase == H_IDLE) ? w_new_hcell : r_hcell;
   assign w_gold_raw  = nib_to_cell(w_lfsr[7:4]);
   assign w_gold_cell = (w_gold_raw == w_haz_cell) ? cell_next(w_gold_raw) : w_gold_raw;

   assign w_hit      = w_play && ((box & r_fire) != 9'd0) && !r_hit_done;
   assign w_collect  = w_play && ((box & r_gold) != 9'd0);

   assign w_life_nxt  = (w_hit && (r_life != 2'd0)) ? r_life - 2'd1 : r_life;
   assign w_score_nxt = (w_collect && (r_score < SCORE_MAX)) ? r_score + 4'd1 : r_score;
   assign w_end       = w_play && ((w_life_nxt == 2'd0) || (w_score_nxt == SCORE_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= G_INIT;
         r_life     <= LIFE_MAX;
         r_score    <= 4'd0;
         r_tick_cnt <= '0;
      end else begin
         case (r_state)
            G_INIT: begin
               r_tick_cnt <= '0;
               if (start) begin
                  r_state <= G_PLAY;
                  r_life  <= LIFE_MAX;
                  r_score <= 4'd0;
               end
            end
            G_PLAY: begin
               r_life  <= w_life_nxt;
               r_score <= w_score_nxt;
               if (w_end) begin
                  r_state    <= G_FINISH;
                  r_tick_cnt <= '0;
               end else if (r_tick_cnt == TICK_LAST) begin
                  r_tick_cnt <= '0;
               end else begin
                  r_tick_cnt <= r_tick_cnt + CNT_W'(1);
               end
            end
            G_FINISH: begin
               r_tick_cnt <= '0;
               if (start) begin
                  r_state <= G_INIT;
               end
            end
            default: begin
               r_state    <= G_INIT;
               r_tick_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hphase   <= H_IDLE;
         r_hcnt     <= '0;
         r_hcell    <= 4'd0;
         r_warn     <= 9'd0;
         r_fire     <= 9'd0;
         r_hit_done <= 1'b0;
      end else if (!w_play || w_end) begin
         r_hphase   <= H_IDLE;
         r_hcnt     <= '0;
         r_warn     <= 9'd0;
         r_fire     <= 9'd0;
         r_hit_done <= 1'b0;
      end else begin
         if (w_hit) begin
            r_hit_done <= 1'b1;
         end
         if (w_tick) begin
            case (r_hphase)
               H_IDLE: begin
                  r_hcell  <= w_new_hcell;
                  r_warn   <= cell_onehot(w_new_hcell);
                  r_hcnt   <= '0;
                  r_hphase <= H_WARN;
               end
               H_WARN: begin
                  if (r_hcnt == WARN_LAST) begin
                     r_fire     <= r_warn;
                     r_warn     <= 9'd0;
                     r_hit_done <= 1'b0;
                     r_hcnt     <= '0;
                     r_hphase   <= H_FIRE;
                  end else begin
                     r_hcnt <= r_hcnt + HC_W'(1);
                  end
               end
               H_FIRE: begin
                  if (r_hcnt == FIRE_LAST) begin
                     r_fire   <= 9'd0;
                     r_hcnt   <= '0;
                     r_hphase <= H_IDLE;
                  end else begin
                     r_hcnt <= r_hcnt + HC_W'(1);
                  end
               end
               default: begin
                  r_hphase <= H_IDLE;
                  r_hcnt   <= '0;
               end
            endcase
         end
      end
   end

   // Collection wins over a same-edge expiry; a fresh spawn waits for the next tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gold <= 9'd0;
         r_gcnt <= '0;
      end else if (!w_play || w_end) begin
         r_gold <= 9'd0;
         r_gcnt <= '0;
      end else if (w_collect) begin
         r_gold <= 9'd0;
         r_gcnt <= '0;
      end else if (w_tick) begin
         if (r_gold == 9'd0) begin
            r_gold <= cell_onehot(w_gold_cell);
            r_gcnt <= '0;
         end else if (r_gcnt == GOLD_LAST) begin
            r_gold <= 9'd0;
            r_gcnt <= '0;
         end else begin
            r_gcnt <= r_gcnt + GC_W'(1);
         end
      end
   end

   assign game_state    = r_state;
   assign warning_state = r_warn;
   assign fire_state    = r_fire;
   assign gold_state    = r_gold;
   assign life          = r_life;
   assign score         = r_score;

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - scoreboard bench for hazard_scheduler
// The reference model schedules hazards by tick index arithmetic; a monitor pops expectations every cycle.
module tb_hazard_scheduler;

   localparam int          TD     = 4;
   localparam int          WT     = 2;
   localparam int          FT     = 2;
   localparam int          GT     = 3;
   localparam int          PERIOD = WT + FT + 1;
   localparam logic [15:0] SEED   = 16'hACE1;

   typedef struct {
      logic [1:0] gs;
      logic [8:0] warn;
      logic [8:0] fire;
      logic [8:0] gold;
      logic [1:0] life;
      logic [3:0] score;
   } exp_t;

   typedef enum int {M_IDLE, M_FIRE, M_GOLD, M_RAND} mode_e;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [8:0] box = 9'd0;
   logic [1:0] game_state;
   logic [8:0] warning_state;
   logic [8:0] fire_state;
   logic [8:0] gold_state;
   logic [1:0] life;
   logic [3:0] score;

   hazard_scheduler #(
      .TICK_DIV   (TD),
      .WARN_TICKS (WT),
      .FIRE_TICKS (FT),
      .GOLD_TICKS (GT),
      .LFSR_SEED  (SEED)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .box           (box),
      .game_state    (game_state),
      .warning_state (warning_state),
      .fire_state    (fire_state),
      .gold_state    (gold_state),
      .life          (life),
      .score         (score)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: game phase 0/1/2, cells as indices (-1 = none).
   int          m_gs, m_life, m_score, m_cyc, m_k;
   int          m_hcell, m_warn_cell, m_fire_cell, m_gcell, m_gexp;
   bit          m_hit_used;
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   function automatic int cell_of(input int n);
      return (n < 9) ? n : n - 9;
   endfunction

   function automatic logic [8:0] bit_of(input int c);
      logic [8:0] v;
      v = 9'd0;
      if (c >= 0) v[c] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_gs = 0; m_life = 3; m_score = 0; m_cyc = 0; m_k = 0;
      m_hcell = -1; m_warn_cell = -1; m_fire_cell = -1; m_gcell = -1; m_gexp = 0;
      m_hit_used = 1'b0;
      m_lfsr = SEED;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.gs    = 2'(m_gs);
      e.warn  = bit_of(m_warn_cell);
      e.fire  = bit_of(m_fire_cell);
      e.gold  = bit_of(m_gcell);
      e.life  = 2'(m_life);
      e.score = 4'(m_score);
      return e;
   endfunction

   task automatic model_step(input logic [8:0] b, input logic s);
      logic [15:0] cur;
      bit hit, got, tick;
      int r, g;
      cur = m_lfsr;
      m_lfsr = lfsr_next(cur);
      if (m_gs == 0) begin
         if (s) begin
            m_gs = 1; m_life = 3; m_score = 0; m_cyc = 0; m_k = 0;
            m_hcell = -1; m_warn_cell = -1; m_fire_cell = -1; m_gcell = -1;
            m_hit_used = 1'b0;
         end
      end else if (m_gs == 2) begin
         if (s) m_gs = 0;
      end else begin
         hit  = (m_fire_cell >= 0) && b[m_fire_cell] && !m_hit_used;
         got  = (m_gcell >= 0) && b[m_gcell];
         tick = (m_cyc % TD) == TD - 1;
         m_cyc++;
         if (hit) begin
            if (m_life > 0) m_life--;
            m_hit_used = 1'b1;
         end
         if (got && m_score < 5) m_score++;
         if (tick) begin
            m_k++;
            r = (m_k - 1) % PERIOD;
            if (r == 0) begin
               m_hcell = cell_of(int'(cur[3:0]));
               m_warn_cell = m_hcell;
            end else if (r == WT) begin
               m_fire_cell = m_warn_cell;
               m_warn_cell = -1;
               m_hit_used = 1'b0;
            end else if (r == WT + FT) begin
               m_fire_cell = -1;
            end
         end
         if (got) begin
            m_gcell = -1;
         end else if (tick) begin
            if (m_gcell < 0) begin
               g = cell_of(int'(cur[7:4]));
               if (g == m_hcell) g = (g + 1) % 9;
               m_gcell = g;
               m_gexp = m_k + GT;
            end else if (m_k == m_gexp) begin
               m_gcell = -1;
            end
         end
         if (m_life == 0 || m_score == 5) begin
            m_gs = 2;
            m_warn_cell = -1; m_fire_cell = -1; m_gcell = -1;
         end
      end
      sb.push_back(model_out());
   endtask

   task automatic check_out(input string name, input exp_t e);
      vectors++;
      if (game_state !== e.gs || warning_state !== e.warn || fire_state !== e.fire ||
          gold_state !== e.gold || life !== e.life || score !== e.score) begin
         miscompares++;
         $display("FAIL %s @%0t: got gs=%b warn=%b fire=%b gold=%b life=%0d score=%0d, want gs=%b warn=%b fire=%b gold=%b life=%0d score=%0d",
                  name, $time, game_state, warning_state, fire_state, gold_state, life, score,
                  e.gs, e.warn, e.fire, e.gold, e.life, e.score);
      end
   endtask

   task automatic check_val(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
      end
   endtask

   function automatic exp_t reset_exp();
      exp_t e;
      e.gs = 2'b00; e.warn = 9'd0; e.fire = 9'd0; e.gold = 9'd0; e.life = 2'd3; e.score = 4'd0;
      return e;
   endfunction

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         check_out("cycle", sb.pop_front());
         vectors++;
         if ($countones(warning_state) > 1 || $countones(fire_state) > 1 || $countones(gold_state) > 1) begin
            miscompares++;
            $display("FAIL onehot @%0t: warn=%b fire=%b gold=%b, want each one-hot or zero",
                     $time, warning_state, fire_state, gold_state);
         end
      end
   end

   function automatic logic [8:0] pick_box(input mode_e m);
      case (m)
         M_FIRE: return bit_of(m_fire_cell);
         M_GOLD: return bit_of(m_gcell);
         M_RAND: begin
            case ($urandom_range(0, 4))
               0: return 9'd0;
               1: return 9'($urandom_range(0, 511));
               2: return bit_of($urandom_range(0, 8));
               3: return bit_of(m_fire_cell);
               default: return bit_of(m_gcell);
            endcase
         end
         default: return 9'd0;
      endcase
   endfunction

   task automatic cycle(input logic [8:0] b, input logic s);
      box = b;
      start = s;
      model_step(b, s);
      @(posedge clk);
      #2;
   endtask

   task automatic run_to_finish(input mode_e m, input int budget, input string name);
      int n;
      n = 0;
      while (m_gs != 2 && n < budget) begin
         cycle(pick_box(m), 1'b0);
         n++;
      end
      check_val({name, "_finish"}, int'(game_state), 2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      model_reset();
      #12;
      rst = 1'b0;
      #1;
      check_out("reset_values", reset_exp());
      repeat (3) cycle(9'd0, 1'b0);

      // Park on every fire: one life per fire phase until the game ends.
      cycle(9'd0, 1'b1);
      check_val("play_entry", int'(game_state), 1);
      run_to_finish(M_FIRE, 400, "fire_hits");
      check_val("fire_hits_life", int'(life), 0);
      check_val("fire_hits_cleared", int'(warning_state | fire_state | gold_state), 0);

      // Untouched gold expiring and respawning, then five collections.
      cycle(9'd0, 1'b1);
      cycle(9'd0, 1'b1);
      repeat (70) cycle(pick_box(M_IDLE), 1'b0);
      run_to_finish(M_GOLD, 400, "gold_chase");
      check_val("gold_chase_score", int'(score), 5);

      // Reset while fire is burning, with start held high.
      cycle(9'd0, 1'b1);
      cycle(9'd0, 1'b1);
      n = 0;
      while (m_fire_cell < 0 && n < 100) begin
         cycle(9'd0, 1'b0);
         n++;
      end
      check_val("fire_before_rst", int'(fire_state != 9'd0), 1);
      rst = 1'b1;
      start = 1'b1;
      #1;
      check_out("async_reset", reset_exp());
      @(posedge clk);
      #1;
      check_out("reset_over_start", reset_exp());
      start = 1'b0;
      rst = 1'b0;
      sb.delete();
      model_reset();
      cycle(9'd0, 1'b0);
      cycle(9'd0, 1'b1);

      // Random play, restarting whenever a game ends; start pulses in PLAY must be ignored.
      for (int i = 0; i < 600; i++) begin
         if (m_gs == 1) cycle(pick_box(M_RAND), 1'($urandom_range(0, 7) == 0));
         else cycle(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
      end

      cycle(9'd0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
